// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Define USR_ROTATE_EN to add the Rot input that turns either shift into a rotate.
module universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SinR,
  input  logic             SinL,
`ifdef USR_ROTATE_EN
  input  logic             Rot,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             SoutR,
  output logic             SoutL
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             fill_r;
  logic             fill_l;

  // Serial fill bits; in rotate mode each shift wraps the bit it pushes out.
  always_comb begin
    fill_r = SinR;
    fill_l = SinL;
`ifdef USR_ROTATE_EN
    if (Rot) begin
      fill_r = state_q[0];
      fill_l = state_q[WIDTH-1];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    if (En) begin
      case (mode_e'(Mode))
        MODE_RIGHT: state_d = {fill_r, state_q[WIDTH-1:1]};
        MODE_LEFT:  state_d = {state_q[WIDTH-2:0], fill_l};
        MODE_LOAD:  state_d = D;
        default:    state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) state_q <= '0;
    else       state_q <= state_d;
  end

  assign Q     = state_q;
  assign Qn    = ~state_q;
  assign SoutR = state_q[0];
  assign SoutL = state_q[WIDTH-1];

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal 2..32).
REQ-002 The block SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RSTn  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port En  input  1  enable; 0 forces hold regardless of Mode.
REQ-005 The block SHALL have port Mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 The block SHALL have port D  input  WIDTH  parallel load data.
REQ-007 The block SHALL have port SinR  input  1  serial input entering the MSB on shift right.
REQ-008 The block SHALL have port SinL  input  1  serial input entering the LSB on shift left.
REQ-009 The block SHALL have port Q  output  WIDTH  registered state.
REQ-010 The block SHALL have port Qn  output  WIDTH  bitwise complement of Q, always consistent with Q.
REQ-011 The block SHALL have port SoutR  output  1  bit shifted out on shift right, equal to Q[0].
REQ-012 The block SHALL have port SoutL  output  1  bit shifted out on shift left, equal to Q[WIDTH-1].

Function
REQ-013 The block SHALL hold one WIDTH-bit state register as its only storage; Q is driven directly from it.
REQ-014 The block SHALL update state only on rising CLK; Q, Qn, SoutR and SoutL change only after an edge, with one-cycle latency from sampled inputs.
REQ-015 On an edge with En=1, Mode=01, the next state SHALL be {SinR, Q[WIDTH-1:1]}.
REQ-016 On an edge with En=1, Mode=10, the next state SHALL be {Q[WIDTH-2:0], SinL}.
REQ-017 On an edge with En=1, Mode=11, the next state SHALL be D.
REQ-018 On an edge with En=1, Mode=00, or with En=0 (any Mode), the state SHALL be unchanged.
REQ-019 Priority SHALL be RSTn low, then En low, then Mode decode.
REQ-020 SinR SHALL be ignored except when shifting right, SinL except when shifting left, and D except in parallel load.
REQ-021 The block SHALL NOT contain level-sensitive latches; every storage element SHALL be edge-triggered on CLK.
REQ-022 Qn SHALL equal ~Q in every cycle, including during and immediately after reset.

Reset
REQ-023 When RSTn is sampled low on a rising CLK, the state SHALL become all zeros: Q=0, Qn=all ones, SoutR=0, SoutL=0.
REQ-024 RSTn low SHALL override any operation in progress, including a load or shift presented on the same edge.
REQ-025 RSTn changes between edges SHALL have no effect on outputs until the next rising CLK.
REQ-026 The first edge with RSTn high SHALL perform the operation selected by En/Mode at that edge.

Configuration
REQ-027 When macro USR_ROTATE_EN is defined, the block SHALL add port Rot  input  1 (rotate select).
REQ-028 With USR_ROTATE_EN defined and Rot=1, shift right SHALL feed Q[0] into the MSB, and shift left SHALL feed Q[WIDTH-1] into the LSB; SinR and SinL SHALL be ignored.
REQ-029 With USR_ROTATE_EN defined and Rot=0, or with the macro undefined, shifts SHALL behave as in REQ-015 and REQ-016.
REQ-030 With USR_ROTATE_EN undefined, port Rot SHALL NOT exist.

Verification
REQ-031 Reset check: WIDTH=8; load D=8'hA5, then RSTn=0 for one edge with Mode=11, D=8'hFF -> Q=8'h00, Qn=8'hFF.
REQ-032 Shift right: load 8'h81, then Mode=01, SinR=0 for 3 edges -> Q=8'h81, 8'h40, 8'h20, 8'h10, with SoutR=1, 0, 0, 0 respectively.
REQ-033 Shift left: load 8'h01, then Mode=10, SinL=1 for 2 edges -> Q=8'h03, then 8'h07; SoutL=0 throughout.
REQ-034 Hold/enable: load 8'h3C, then En=0 with Mode=11, D=8'h00 for 4 edges -> Q remains 8'h3C.
REQ-035 Rotate (USR_ROTATE_EN defined): load 8'h81, then Rot=1, Mode=01 for 1 edge -> Q=8'hC0; then Mode=10 for 1 edge -> Q=8'h81.
REQ-036 Every checked cycle in all scenarios: Qn == ~Q, SoutR == Q[0], SoutL == Q[7].
